// File: rtl/bsg_relay_fifo_param.sv
// Parametrised relay FIFO: registered ready_o, occupancy count, almost-full flag and synchronous flush.
// Circular buffer with explicit pointer wrap so any els_p >= 2 is supported.
module bsg_relay_fifo_param #(
  parameter int width_p        = 16,
  parameter int els_p          = 4,
  parameter int afull_thresh_p = els_p - 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int unsigned ptr_w_lp = (els_p > 2) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0] afull_cnt_lp = cnt_w_lp'(afull_thresh_p);

  if (els_p < 2) begin : g_bad_els
    $error("bsg_relay_fifo_param: els_p must be >= 2");
  end
  if (afull_thresh_p < 1 || afull_thresh_p > els_p) begin : g_bad_thresh
    $error("bsg_relay_fifo_param: afull_thresh_p must be in 1..els_p");
  end
  if (width_p < 1) begin : g_bad_width
    $error("bsg_relay_fifo_param: width_p must be >= 1");
  end

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [ptr_w_lp-1:0] wptr_n, rptr_n;
  logic [cnt_w_lp-1:0] count_r, count_n;
  logic                flush;
  logic                enq, deq;

  // Flush (reset or clear) masks both handshakes so nothing moves in that cycle.
  assign flush   = reset_i | clear_i;
  assign ready_o = (count_r != full_cnt_lp) & ~flush;
  assign v_o     = (count_r != '0) & ~flush;
  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_i;

  assign data_o        = mem_r[rptr_r];
  assign count_o       = count_r;
  assign almost_full_o = (count_r >= afull_cnt_lp) & ~flush;

  always_comb begin
    wptr_n  = wptr_r;
    rptr_n  = rptr_r;
    count_n = count_r;
    if (enq) begin
      wptr_n = (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
    end
    if (deq) begin
      rptr_n = (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
    end
    unique case ({enq, deq})
      2'b10:   count_n = count_r + 1'b1;
      2'b01:   count_n = count_r - 1'b1;
      default: count_n = count_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      wptr_r  <= wptr_n;
      rptr_r  <= rptr_n;
      count_r <= count_n;
    end
  end

  // Storage is deliberately not reset; v_o qualifies data_o.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (v_o && !ready_i) |=> (clear_i || reset_i || (v_o && $stable(data_o))))
    else $error("bsg_relay_fifo_param: output changed while stalled");

  a_count_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    count_r <= full_cnt_lp)
    else $error("bsg_relay_fifo_param: count exceeds els_p");

endmodule

// File: doc/bsg_relay_fifo_param.md
Name: bsg_relay_fifo_param

Overview:
- Parametrised successor to the fixed 2-entry relay FIFO; generalised in width and depth.
- Valid/ready on both sides: ready_i in, yumi generated internally.
- Adds occupancy count, almost-full flag and synchronous flush.
- Sits on link/relay boundaries where registered ready_o is needed and one- or two-slot buffering is insufficient.

Parameters:
- width_p, 16, data width in bits (>=1).
- els_p, 4, number of storage entries (>=2). Need not be a power of 2.
- afull_thresh_p, els_p-1, almost_full_o asserts when occupancy >= this value (1..els_p).

Ports:
- clk_i  input  1  single clock, all state on posedge.
- reset_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush; empties FIFO without reset.
- v_i  input  1  input data valid.
- data_i  input  width_p  input data.
- ready_o  output  1  FIFO can accept (not full, not clearing).
- v_o  output  1  output data valid (not empty, not clearing).
- data_o  output  width_p  head-entry data.
- ready_i  input  1  consumer ready; deq = v_o & ready_i.
- count_o  output  $clog2(els_p+1)  current occupancy, 0..els_p.
- almost_full_o  output  1  count_o >= afull_thresh_p.

Behaviour:
- State registers: wptr_r, rptr_r (each $clog2(els_p) bits, min 1), count_r. Storage array of els_p x width_p, not reset.
- Storage is a 1r1w array: write port at wptr_r; asynchronous read at rptr_r drives data_o.
- Reset (reset_i=1 at posedge): wptr_r=0, rptr_r=0, count_r=0. Next cycle: v_o=0, ready_o=1, count_o=0, almost_full_o=0. data_o is don't-care while v_o=0.
- During reset_i=1, ready_o=0 and v_o=0; no handshakes occur.
- enq = v_i & ready_o. ready_o = (count_r != els_p) & ~clear_i & ~reset_i.
  - ready_o depends only on registered state, clear_i and reset_i; no combinational path from ready_i or v_i.
- deq = v_o & ready_i. v_o = (count_r != 0) & ~clear_i & ~reset_i.
- On enq: mem[wptr_r] <= data_i; wptr_r advances by 1, wrapping from els_p-1 to 0 (explicit compare, not modulo-2^n).
- On deq: rptr_r advances with the same wrap rule.
- count_r next = count_r + enq - deq; never exceeds els_p or underflows.
- Latency: data accepted at edge N is visible at data_o with v_o=1 after edge N if the FIFO was empty. No same-cycle bypass.
- Full: ready_o=0 even if deq occurs that cycle. A slot freed by deq is offered from the next cycle.
- Empty: v_o=0. Enq alone sets count=1 and v_o=1 next cycle.
- Simultaneous enq & deq when 0<count<els_p: both pointers advance, count unchanged, FIFO order preserved.
- Wrap-around: order must be preserved across any number of pointer wraps, including non-power-of-2 els_p.
- clear_i=1 at posedge: wptr_r=rptr_r=count_r=0. Same-cycle v_i/ready_i are ignored (ready_o=v_o=0). Storage contents are left as-is. If clear_i and reset_i are both high, the result is identical.
- Reset or clear mid-stream discards all buffered entries; no partial word is ever emitted.
- almost_full_o is a combinational decode of count_r and is forced 0 during clear_i/reset_i.
- Elaboration assertions: els_p>=2, 1<=afull_thresh_p<=els_p, width_p>=1.
- Sim assertions:
  - data_o/v_o are stable while v_o=1 and ready_i=0, absent clear.
  - count_r never exceeds els_p.

Test Plan:
- Reset, then v_i=1 with data 0x0001..0x0004, ready_i=0, els_p=4 -> ready_o drops after 4th accept. count_o=4. almost_full_o=1 from count 3. v_o=1, data_o=0x0001.
- Full FIFO, v_i=1 data 0x00AA, ready_i=1 for one cycle -> 0x0001 dequeued, 0x00AA not accepted that cycle. Next cycle ready_o=1, count_o=3, data_o=0x0002.
- Continuous streaming: v_i=ready_i=1 for 20 cycles with incrementing data, els_p=3 -> output sequence is exactly the input sequence across 6+ pointer wraps. Steady count_o=1, one beat per cycle after 1-cycle fill.
- Empty FIFO, single enq 0xBEEF with ready_i=1 -> v_o=0 in the accept cycle; v_o=1, data_o=0xBEEF the next cycle; count_o returns 0 after dequeue.
- FIFO holding 3 entries, clear_i=1 with v_i=1 and ready_i=1 -> no enq/deq that cycle. Next cycle count_o=0, v_o=0, ready_o=1. A subsequent enq 0x1234 is the next word out.
- reset_i asserted mid-stream with 2 entries buffered -> next cycle v_o=0, count_o=0, ready_o=1. Stale entries are never emitted afterwards.
